hilo_muldiv: RTL and testbench
==============================

// Module: hilo_muldiv
// PURPOSE
//  Iterative multiply/divide unit and owner of the HI/LO register pair.
//  Sits in EX beside the ALU and writes the 64-bit HI/LO value that the
//  forwarding/readback mux consumes via its hlsel half-select.
//  Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  The pipeline stalls on busy; MFHI/MFLO read hilo_o[63:32]/[31:0].
// PARAMETERS
//  XLEN   32  operand width; hilo_o is 2*XLEN; iteration count = XLEN
//  CNT_W   6  iteration counter width, >= clog2(XLEN+1)
// PORTS
//  clk     in   1       rising-edge clock
//  rst     in   1       synchronous, active-high reset
//  start   in   1       request strobe, sampled only in IDLE
//  op      in   3       000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//  a       in   XLEN    rs operand (dividend/multiplicand/move source)
//  b       in   XLEN    rt operand (divisor/multiplier)
//  hilo_o  out  2*XLEN  {HI,LO}; registered
//  busy    out  1       1 while a mul/div is in flight
//  done    out  1       one-cycle pulse on the edge that commits a mul/div result
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, hilo_o=0, busy=0, done=0, counter=0.
//   rst mid-operation aborts it with no commit.
//  States: IDLE -> RUN (XLEN edges) -> FIX (1 edge) -> IDLE.
//  IDLE, start=1, op=MTHI: next edge HI<=a, LO unchanged; no busy, no done.
//  IDLE, start=1, op=MTLO: next edge LO<=a, HI unchanged; no busy, no done.
//  IDLE, start=1, op=mul/div: edge E0 latches |a|,|b| (signed ops) or a,b (unsigned).
//   Result sign bits are captured. Then RUN, busy=1 from E0.
//   Signed magnitudes use XLEN-bit unsigned math; |0x80000000| = 0x80000000.
//  RUN, multiply: shift-add, one multiplier bit per edge, 2*XLEN-bit accumulator.
//  RUN, divide: restoring division, one quotient bit per edge, XLEN+1-bit partial remainder.
//  The counter increments per RUN edge. Leave RUN after edge E(XLEN).
//  FIX (edge E(XLEN+1)): apply sign correction and write hilo_o. done=1 for the following cycle.
//   busy=0 after this edge.
//   Total: result visible XLEN+1 edges after start (33 for XLEN=32).
//  Sign rules: product negated if sign(a)^sign(b).
//   Quotient negated if sign(a)^sign(b); remainder takes the sign of a.
//  DIV result: HI=remainder, LO=quotient.
//   0x80000000/-1 gives LO=0x80000000, HI=0 (wraps, no trap).
//  Divide by zero (b=0, DIV or DIVU): still XLEN+1 edges. HI=a (original), LO={XLEN{1}}.
//  start while busy: ignored, including MTHI/MTLO. hilo_o is unchanged until FIX.
//  hilo_o changes only on MTHI/MTLO edges, FIX edges and reset.
//  start=1 on the same cycle that FIX commits: ignored. A new start is accepted from the next IDLE cycle.
//  Undefined op values (110, 111): no state change.
// TESTING
//  MULT a=-3 (0xFFFFFFFD), b=7 -> after 33 edges hilo_o=64'hFFFFFFFF_FFFFFFEB.
//   done is high exactly 1 cycle; busy high for cycles 1..33.
//  MULTU a=b=0xFFFFFFFF -> hilo_o=64'hFFFFFFFE_00000001.
//   The same operands with MULT -> 64'h00000000_00000001.
//  DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   DIVU a=7, b=2 -> LO=3, HI=1.
//  DIVU a=0x1234, b=0 -> HI=0x00001234, LO=0xFFFFFFFF.
//   DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
//  MTHI 0xAAAA5555 then MTLO 0x0F0F0F0F in consecutive cycles -> hilo_o=64'hAAAA5555_0F0F0F0F.
//   No busy/done. MTHI issued while busy -> ignored.
//  MULT started, rst=1 at edge 10 -> hilo_o=0, busy=0, done never pulses.
//   A new MULTU 2*3 then gives hilo_o=6.

Source files
------------

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative mul/div unit owning HI/LO; ports clk, rst, start, op, a, b -> hilo_o {HI,LO}, busy, done
module hilo_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] hilo_o,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2*XLEN:0] w;
  logic [XLEN-1:0] m;
  logic is_div, neg_q, neg_r, dz;
  logic sgn_a, sgn_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0] mul_up, r_sh, diff;
  logic [2*XLEN:0] mul_nx, div_nx;
  logic [XLEN-1:0] q, r, q_fix, r_fix;
  logic [2*XLEN-1:0] prod, fix_val;
  // op[0] selects unsigned, op[1] selects divide
  assign sgn_a = ~op[0] & a[XLEN-1];
  assign sgn_b = ~op[0] & b[XLEN-1];
  assign abs_a = sgn_a ? -a : a;
  assign abs_b = sgn_b ? -b : b;
  // multiply: w[2X-1:X] accumulates, w[X-1:0] holds the multiplier shifting out
  assign mul_up = {1'b0, w[2*XLEN-1:XLEN]} + (w[0] ? {1'b0, m} : '0);
  assign mul_nx = {1'b0, mul_up, w[XLEN-1:1]};
  // divide: w[2X:X] is the partial remainder, w[X-1:0] shifts dividend out and quotient in
  assign r_sh   = {w[2*XLEN-1:XLEN], w[XLEN-1]};
  assign diff   = r_sh - {1'b0, m};
  assign div_nx = diff[XLEN] ? {r_sh, w[XLEN-2:0], 1'b0} : {diff, w[XLEN-2:0], 1'b1};
  assign prod   = w[2*XLEN-1:0];
  assign q      = w[XLEN-1:0];
  assign r      = w[2*XLEN-1:XLEN];
  // a zero divisor yields all-ones quotient; remainder naturally ends as |a| and re-signs to a
  assign q_fix  = dz ? {XLEN{1'b1}} : (neg_q ? -q : q);
  assign r_fix  = neg_r ? -r : r;
  assign fix_val = is_div ? {r_fix, q_fix} : (neg_q ? -prod : prod);
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hilo_o <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      w      <= '0;
      m      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (op == 3'b100) hilo_o[2*XLEN-1:XLEN] <= a;
          else if (op == 3'b101) hilo_o[XLEN-1:0] <= a;
          else if (!op[2]) begin
            state  <= RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= sgn_a ^ sgn_b;
            neg_r  <= sgn_a;
            dz     <= op[1] & ~|b;
            m      <= op[1] ? abs_b : abs_a;
            w      <= {{(XLEN+1){1'b0}}, op[1] ? abs_a : abs_b};
          end
        end
        RUN: begin
          w   <= is_div ? div_nx : mul_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          hilo_o <= fix_val;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: randomized self-checking bench for hilo_muldiv against an arithmetic reference model
module tb_hilo_muldiv;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic [63:0] hilo_o, exp_hl;
  logic busy, done;
  int n_tests = 0, n_fail = 0;

  hilo_muldiv dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
                   .hilo_o(hilo_o), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 3'd0) begin
      p = sx * sy;
      return p;
    end
    if (o == 3'd1) return {32'b0, x} * {32'b0, y};
    if (y == 0) return {x, 32'hFFFFFFFF};
    if (o == 3'd3) return {x % y, x / y};
    qq = sx / sy;
    rr = sx % sy;
    return {rr[31:0], qq[31:0]};
  endfunction

  task automatic muldiv(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    logic [63:0] want;
    want = model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_at_start", {63'b0, busy}, 64'd1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      // stray requests while busy, including one during the commit cycle, must be ignored
      if (i == 5 || i == 33) begin
        start = 1'b1; op = (i == 5) ? 3'b100 : 3'b101; a = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (i < 33 && done) check("early_done", {63'b0, done}, 64'd0);
      if (i < 33 && !busy) check("busy_during", {63'b0, busy}, 64'd1);
      if (done) begin n = i; break; end
    end
    check("latency", 64'(n), 64'd33);
    check($sformatf("result op%0d a=%h b=%h", o, x, y), hilo_o, want);
    check("busy_after", {63'b0, busy}, 64'd0);
    exp_hl = want;
    @(posedge clk); #1;
    check("done_one_cycle", {63'b0, done}, 64'd0);
    check("hold_after", hilo_o, exp_hl);
  endtask

  task automatic move(input logic [2:0] o, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x;
    @(posedge clk); #1;
    start = 1'b0;
    if (o == 3'b100) exp_hl[63:32] = x;
    else if (o == 3'b101) exp_hl[31:0] = x;
    check($sformatf("move op%0d", o), hilo_o, exp_hl);
    check("move_nobusy", {62'b0, busy, done}, 64'd0);
  endtask

  initial begin
    exp_hl = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_hilo", hilo_o, 64'd0);
    check("reset_flags", {62'b0, busy, done}, 64'd0);

    muldiv(3'd0, 32'hFFFFFFFD, 32'd7);
    check("mult_neg3x7", hilo_o, 64'hFFFFFFFF_FFFFFFEB);
    muldiv(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    muldiv(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    muldiv(3'd2, 32'hFFFFFFF9, 32'd2);
    check("div_neg7_2", hilo_o, 64'hFFFFFFFF_FFFFFFFD);
    muldiv(3'd3, 32'd7, 32'd2);
    muldiv(3'd3, 32'h1234, 32'd0);
    check("divu_by0", hilo_o, 64'h00001234_FFFFFFFF);
    muldiv(3'd2, 32'hFFFFEDCC, 32'd0);
    muldiv(3'd2, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf", hilo_o, 64'h00000000_80000000);
    muldiv(3'd0, 32'h80000000, 32'h80000000);

    move(3'b100, 32'hAAAA5555);
    move(3'b101, 32'h0F0F0F0F);
    check("mthi_mtlo", hilo_o, 64'hAAAA5555_0F0F0F0F);
    move(3'b110, $urandom);
    move(3'b111, $urandom);

    for (int k = 0; k < 24; k++) begin
      logic [31:0] x, y;
      logic [2:0] o;
      x = $urandom;
      y = $urandom;
      o = 3'($urandom_range(0, 3));
      if (k % 6 == 1) y = 32'd0;
      if (k % 6 == 2) x = 32'h80000000;
      if (k % 6 == 3) y = 32'($urandom_range(1, 9)) * ((k % 12 == 3) ? 32'hFFFFFFFF : 32'd1);
      if (k % 8 == 7) move(3'($urandom_range(4, 5)), x);
      else muldiv(o, x, y);
    end

    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_hl = '0;
    check("abort_hilo", hilo_o, 64'd0);
    check("abort_flags", {62'b0, busy, done}, 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done || busy) seen = 1'b1;
      end
      check("abort_no_done", {63'b0, seen}, 64'd0);
    end
    muldiv(3'd1, 32'd2, 32'd3);
    check("after_abort", hilo_o, 64'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
